// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch, loader and imem-macro signals around the instruction-memory arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the memory macro.
interface imem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  // Fetch port
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_stall;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  // Loader / debug port
  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  // Memory macro
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output f_stall, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  f_stall, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port imem arbiter: fetch has priority, the loader is guaranteed a slot after
// MAX_WAIT consecutive denied cycles. Read data returns one cycle after the grant.
module imem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  imem_arbiter_if.slave  bus
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_F    = 2'd1;
  localparam logic [1:0] OWN_L    = 2'd2;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [1:0] rd_own_q, rd_own_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       force_l, grant_l, grant_f;

  // Every combinational output is gated by reset so nothing reaches the macro or
  // the requesters while reset is held, independent of the clock.
  assign force_l = bus.l_req & (wait_cnt_q >= MAX_WAIT_C);
  assign grant_l = reset & bus.l_req & (~bus.f_req | force_l);
  assign grant_f = reset & bus.f_req & ~grant_l;

  assign bus.l_gnt   = grant_l;
  assign bus.f_stall = reset & bus.f_req & ~grant_f;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant_l) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.l_we;
      bus.mem_addr  = bus.l_addr;
      bus.mem_wdata = bus.l_wdata;
    end else if (grant_f) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.f_addr;
    end
  end

  always_comb begin
    rd_own_d = OWN_NONE;
    if (grant_f)                  rd_own_d = OWN_F;
    else if (grant_l && !bus.l_we) rd_own_d = OWN_L;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.l_req || grant_l)    wait_cnt_d = 4'd0;
    else if (wait_cnt_q != 4'hF)  wait_cnt_d = wait_cnt_q + 4'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: only the owner tag and starvation counter are reset; the read data path is gated, not stored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_own_q   <= OWN_NONE;
      wait_cnt_q <= 4'd0;
    end else begin
      rd_own_q   <= rd_own_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // The owner register clears asynchronously, so an in-flight read dies with reset.
  assign bus.f_rvalid = (rd_own_q == OWN_F);
  assign bus.l_rvalid = (rd_own_q == OWN_L);
  assign bus.f_rdata  = bus.f_rvalid ? bus.mem_rdata : '0;
  assign bus.l_rdata  = bus.l_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: stimulus pushes expected read data into per-port
// queues, a negedge monitor pops and compares whenever an rvalid is presented.
module tb_imem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) ifa ();
  imem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) ifb ();

  imem_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_WAIT(4)) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifa)
  );

  imem_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_WAIT(0)) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifb)
  );

  // Registered-output memory model behind dut_a; dut_b only ever writes.
  logic [31:0] mem_a [512];
  always @(posedge clk) begin
    if (ifa.mem_en) begin
      if (ifa.mem_we) mem_a[ifa.mem_addr] <= ifa.mem_wdata;
      else            ifa.mem_rdata       <= mem_a[ifa.mem_addr];
    end
  end
  assign ifb.mem_rdata = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_f [$];
  logic [31:0] exp_l [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.f_req = 1'b0; ifa.l_req = 1'b0; ifa.l_we = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (ifa.f_rvalid === 1'b1) begin
      if (exp_f.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL f_rvalid unexpected: got data 0x%08h expected no response", ifa.f_rdata);
      end else begin
        check("f_rdata", ifa.f_rdata, exp_f.pop_front());
      end
    end
    if (ifa.l_rvalid === 1'b1) begin
      if (exp_l.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL l_rvalid unexpected: got data 0x%08h expected no response", ifa.l_rdata);
      end else begin
        check("l_rdata", ifa.l_rdata, exp_l.pop_front());
      end
    end
    if (ifb.f_rvalid === 1'b1 || ifb.l_rvalid === 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL b_rvalid unexpected: got f=%0b l=%0b expected 0 0", ifb.f_rvalid, ifb.l_rvalid);
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) mem_a[i] = 32'hA0 + 32'(i);
    mem_a[9'h10] = 32'hDEADBEEF;

    // Reset: combinational outputs forced low even with both requests raised
    rst_n = 1'b0;
    ifa.f_req = 1'b1; ifa.f_addr = 9'h40; ifa.l_req = 1'b1; ifa.l_we = 1'b1;
    ifa.l_addr = 9'h0; ifa.l_wdata = 32'h0;
    ifb.f_req = 1'b0; ifb.f_addr = 9'h0; ifb.l_req = 1'b0; ifb.l_we = 1'b0;
    ifb.l_addr = 9'h0; ifb.l_wdata = 32'h0;
    #2;
    check("rst f_stall",  32'(ifa.f_stall),  32'h0);
    check("rst l_gnt",    32'(ifa.l_gnt),    32'h0);
    check("rst mem_en",   32'(ifa.mem_en),   32'h0);
    check("rst mem_we",   32'(ifa.mem_we),   32'h0);
    check("rst f_rvalid", 32'(ifa.f_rvalid), 32'h0);
    check("rst wait_cnt", 32'(dut_a.wait_cnt_q), 32'h0);
    idle_a();
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch only: 0x40..0x43 -> 0xE0..0xE3, never stalled
    for (int c = 0; c < 4; c++) begin
      step();
      ifa.f_req = 1'b1; ifa.f_addr = 9'(9'h40 + c);
      exp_f.push_back(32'hE0 + 32'(c));
      @(negedge clk);
      check("fetch f_stall",  32'(ifa.f_stall),  32'h0);
      check("fetch mem_addr", 32'(ifa.mem_addr), 32'h40 + 32'(c));
    end
    step(); idle_a();
    step();

    // Starvation with MAX_WAIT=4: loader wins only in cycle 4
    for (int c = 0; c < 6; c++) begin
      step();
      ifa.f_req = 1'b1; ifa.f_addr = 9'(9'h50 + c);
      ifa.l_req = (c <= 4); ifa.l_we = 1'b0; ifa.l_addr = 9'h10;
      if (c == 4) exp_l.push_back(32'hDEADBEEF);
      else        exp_f.push_back(32'hF0 + 32'(c));
      @(negedge clk);
      check("starve l_gnt",   32'(ifa.l_gnt),   (c == 4) ? 32'h1 : 32'h0);
      check("starve f_stall", 32'(ifa.f_stall), (c == 4) ? 32'h1 : 32'h0);
      if (c == 3) check("starve wait_cnt", 32'(dut_a.wait_cnt_q), 32'h3);
      if (c == 5) check("starve f_rvalid c5", 32'(ifa.f_rvalid), 32'h0);
    end
    step(); idle_a();
    step();

    // Loader write then fetch read of the same word
    step();
    ifa.l_req = 1'b1; ifa.l_we = 1'b1; ifa.l_addr = 9'h20; ifa.l_wdata = 32'h12345678;
    @(negedge clk);
    check("wr l_gnt",     32'(ifa.l_gnt),     32'h1);
    check("wr mem_we",    32'(ifa.mem_we),    32'h1);
    check("wr mem_wdata", ifa.mem_wdata,      32'h12345678);
    step();
    idle_a(); ifa.f_req = 1'b1; ifa.f_addr = 9'h20;
    exp_f.push_back(32'h12345678);
    @(negedge clk);
    check("rd f_stall", 32'(ifa.f_stall), 32'h0);
    check("rd mem_we",  32'(ifa.mem_we),  32'h0);
    step(); idle_a();
    step();

    // Loader alone: granted immediately, counter stays at zero
    step();
    ifa.l_req = 1'b1; ifa.l_we = 1'b0; ifa.l_addr = 9'h05;
    exp_l.push_back(32'hA5);
    @(negedge clk);
    check("lidle l_gnt",    32'(ifa.l_gnt),   32'h1);
    check("lidle f_stall",  32'(ifa.f_stall), 32'h0);
    check("lidle wait_cnt", 32'(dut_a.wait_cnt_q), 32'h0);
    step(); idle_a();
    step();

    // MAX_WAIT=0: loader wins every cycle
    for (int c = 0; c < 3; c++) begin
      step();
      ifb.f_req = 1'b1; ifb.f_addr = 9'h40;
      ifb.l_req = 1'b1; ifb.l_we = 1'b1; ifb.l_addr = 9'(c); ifb.l_wdata = 32'(c);
      @(negedge clk);
      check("mw0 l_gnt",   32'(ifb.l_gnt),   32'h1);
      check("mw0 f_stall", 32'(ifb.f_stall), 32'h1);
      check("mw0 mem_addr", 32'(ifb.mem_addr), 32'(c));
    end
    step();
    ifb.f_req = 1'b0; ifb.l_req = 1'b0; ifb.l_we = 1'b0;
    @(negedge clk);
    check("mw0 idle mem_en", 32'(ifb.mem_en), 32'h0);

    // Reset in the middle of a fetch read
    step();
    ifa.f_req = 1'b1; ifa.f_addr = 9'h40; ifa.l_req = 1'b1; ifa.l_we = 1'b0; ifa.l_addr = 9'h30;
    exp_f.push_back(32'hE0);
    step();
    ifa.f_addr = 9'h41;
    @(negedge clk);
    check("pre-rst f_stall",  32'(ifa.f_stall), 32'h0);
    check("pre-rst wait_cnt", 32'(dut_a.wait_cnt_q), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid-rst f_rvalid", 32'(ifa.f_rvalid), 32'h0);
    check("mid-rst f_rdata",  ifa.f_rdata,       32'h0);
    check("mid-rst mem_en",   32'(ifa.mem_en),   32'h0);
    check("mid-rst f_stall",  32'(ifa.f_stall),  32'h0);
    check("mid-rst wait_cnt", 32'(dut_a.wait_cnt_q), 32'h0);
    idle_a();
    @(negedge clk);
    check("in-rst f_rvalid", 32'(ifa.f_rvalid), 32'h0);
    rst_n = 1'b1;
    step();
    ifa.f_req = 1'b1; ifa.f_addr = 9'h42;
    exp_f.push_back(32'hE2);
    @(negedge clk);
    check("post-rst f_rvalid", 32'(ifa.f_rvalid), 32'h0);
    check("post-rst f_stall",  32'(ifa.f_stall),  32'h0);
    check("post-rst mem_en",   32'(ifa.mem_en),   32'h1);
    step(); idle_a();
    step();
    step();

    check("f queue drained", 32'(exp_f.size()), 32'h0);
    check("l queue drained", 32'(exp_l.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
